// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: PC hand-off, instruction-memory request/ack and decoder valid/ready.
// Perf counter signals appear only when FETCH_PERF_EN is defined.
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc_addr;
  logic              inc_pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              fetch_err;
`ifdef FETCH_PERF_EN
  logic [31:0]       fetch_count;
  logic [31:0]       stall_cycles;
`endif

  modport master (
    input  pc_addr, mem_ack, mem_rdata, instr_ready,
    output inc_pc, mem_req, mem_addr, instr, instr_pc, instr_valid, fetch_err
`ifdef FETCH_PERF_EN
    , output fetch_count, stall_cycles
`endif
  );

  modport slave (
    output pc_addr, mem_ack, mem_rdata, instr_ready,
    input  inc_pc, mem_req, mem_addr, instr, instr_pc, instr_valid, fetch_err
`ifdef FETCH_PERF_EN
    , input fetch_count, stall_cycles
`endif
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: latch PC, request memory, hold word for decoder, pulse inc_pc (FETCH_PERF_EN adds counters).
// Latency: 1 cycle after ack to instr_valid; 3 cycles/instr at best; decoder stalls hold VALID indefinitely, memory stalls time out after MAX_WAIT.
module fetch_unit #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_VALID = 3'd2;
  localparam logic [2:0] S_ADV   = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [2:0]        state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              inc_pc_q, inc_pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic [7:0]        wait_inc;
`ifdef FETCH_PERF_EN
  logic [31:0]       fetch_count_q, fetch_count_d;
  logic [31:0]       stall_cycles_q, stall_cycles_d;
`endif

  assign wait_inc = wait_cnt_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    inc_pc_d      = inc_pc_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fetch_err_d   = fetch_err_q;
    case (state_q)
      S_IDLE: begin
        mem_addr_d = bus.pc_addr;
        mem_req_d  = 1'b1;
        wait_cnt_d = 8'd0;
        state_d    = S_REQ;
      end
      S_REQ: begin
        if (bus.mem_ack) begin
          instr_d       = bus.mem_rdata;
          instr_pc_d    = mem_addr_q;
          instr_valid_d = 1'b1;
          mem_req_d     = 1'b0;
          state_d       = S_VALID;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc == MAX_WAIT_C) begin
            mem_req_d   = 1'b0;
            fetch_err_d = 1'b1;
            state_d     = S_ERR;
          end
        end
      end
      S_VALID: begin
        if (bus.instr_ready) begin
          instr_valid_d = 1'b0;
          inc_pc_d      = 1'b1;
          state_d       = S_ADV;
        end
      end
      S_ADV: begin
        // PC has already moved to its next/jump target during this cycle
        inc_pc_d   = 1'b0;
        mem_addr_d = bus.pc_addr;
        mem_req_d  = 1'b1;
        wait_cnt_d = 8'd0;
        state_d    = S_REQ;
      end
      S_ERR: state_d = S_ERR;
      default: begin
        inc_pc_d      = 1'b0;
        mem_req_d     = 1'b0;
        instr_valid_d = 1'b0;
        state_d       = S_IDLE;
      end
    endcase
  end

`ifdef FETCH_PERF_EN
  always_comb begin
    fetch_count_d  = fetch_count_q;
    stall_cycles_d = stall_cycles_q;
    if (state_q == S_VALID && bus.instr_ready)
      fetch_count_d = fetch_count_q + 32'd1;
    if ((state_q == S_REQ && !bus.mem_ack) || (state_q == S_VALID && !bus.instr_ready))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.fetch_count  = fetch_count_q;
  assign bus.stall_cycles = stall_cycles_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      inc_pc_q      <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      inc_pc_q      <= inc_pc_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  assign bus.inc_pc      = inc_pc_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.fetch_err   = fetch_err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: rule-based fetch model checked every cycle plus directed literal checks.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
  fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) ifb ();

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(255)) u_a (.clk(clk), .rst(rst_a), .bus(ifa));
  fetch_unit #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4))   u_b (.clk(clk), .rst(rst_b), .bus(ifb));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h00A00093;
    return {a[15:0], 16'h0000} ^ 32'h13579BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus knobs for DUT A ----------------
  int          wait_cfg = 0;
  int          stall_cfg = 0;
  int          req_run = 0;
  int          val_run = 0;
  logic        jmp_vld = 1'b0;
  logic [31:0] jmp_tgt = '0;

  // One clock: sample A's outputs just after the edge, then drive memory/decoder/PC for this cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (ifa.mem_req) begin
      if (req_run >= wait_cfg) begin
        ifa.mem_ack   = 1'b1;
        ifa.mem_rdata = mem_word(ifa.mem_addr);
        req_run       = 0;
      end else begin
        ifa.mem_ack   = 1'b0;
        ifa.mem_rdata = 32'hBAD0BAD0;
        req_run++;
      end
    end else begin
      ifa.mem_ack = 1'b0;
      req_run     = 0;
    end
    if (ifa.instr_valid) begin
      if (val_run >= stall_cfg) begin
        ifa.instr_ready = 1'b1;
        val_run         = 0;
      end else begin
        ifa.instr_ready = 1'b0;
        val_run++;
      end
    end else begin
      ifa.instr_ready = 1'b0;
      val_run         = 0;
    end
    if (ifa.inc_pc) begin
      ifa.pc_addr = jmp_vld ? jmp_tgt : ifa.pc_addr + 32'd1;
      jmp_vld     = 1'b0;
    end
  endtask

  // Step until the inc_pc pulse of one fetch, summarising what was observed.
  task automatic run_fetch(output int reqs, output int valids, output logic [31:0] first_addr,
                           output logic [31:0] last_ipc, output logic [31:0] last_instr,
                           output int unstable);
    bit done = 0;
    reqs = 0; valids = 0; unstable = 0;
    first_addr = '0; last_ipc = '0; last_instr = '0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (ifa.mem_req) begin
        if (reqs == 0) first_addr = ifa.mem_addr;
        else if (ifa.mem_addr != first_addr) unstable++;
        reqs++;
      end
      if (ifa.instr_valid) begin
        valids++;
        last_ipc   = ifa.instr_pc;
        last_instr = ifa.instr;
      end
      if (ifa.inc_pc) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("fetch_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- per-cycle model of DUT A ----------------
  // Rules: a request runs from IDLE+1 or the cycle after inc_pc until acked; data is valid the
  // cycle after an ack and until accepted; inc_pc follows acceptance by one cycle.
  int          cyc = 0;
  bit          in_reset = 1;
  logic        p_req, p_ack, p_vld, p_rdy, p_inc;
  logic [31:0] fetch_addr;
  logic        exp_req, exp_vld, exp_inc;
  logic [31:0] exp_fc, exp_st;

  always @(negedge clk) begin
    if (!rst_a) begin
      chk("rst_mem_req", ifa.mem_req, 0);
      chk("rst_inc_pc", ifa.inc_pc, 0);
      chk("rst_instr_valid", ifa.instr_valid, 0);
      chk("rst_fetch_err", ifa.fetch_err, 0);
      chk("rst_instr", ifa.instr, 0);
      chk("rst_instr_pc", ifa.instr_pc, 0);
      chk("rst_mem_addr", ifa.mem_addr, 0);
`ifdef FETCH_PERF_EN
      chk("rst_fetch_count", ifa.fetch_count, 0);
      chk("rst_stall_cycles", ifa.stall_cycles, 0);
`endif
      in_reset = 1;
      {p_req, p_ack, p_vld, p_rdy, p_inc} = '0;
      exp_fc = '0;
      exp_st = '0;
    end else begin
      cyc      = in_reset ? 0 : cyc + 1;
      in_reset = 0;
      if (cyc == 0) fetch_addr = ifa.pc_addr;
      exp_req = (cyc == 1) || (p_req && !p_ack) || p_inc;
      exp_vld = (p_req && p_ack) || (p_vld && !p_rdy);
      exp_inc = p_vld && p_rdy;
      exp_fc  = exp_fc + ((p_vld && p_rdy) ? 32'd1 : 32'd0);
      exp_st  = exp_st + (((p_req && !p_ack) || (p_vld && !p_rdy)) ? 32'd1 : 32'd0);
      chk("m_mem_req", ifa.mem_req, exp_req);
      chk("m_instr_valid", ifa.instr_valid, exp_vld);
      chk("m_inc_pc", ifa.inc_pc, exp_inc);
      chk("m_fetch_err", ifa.fetch_err, 0);
      if (ifa.mem_req) chk("m_mem_addr", ifa.mem_addr, fetch_addr);
      if (ifa.instr_valid) begin
        chk("m_instr", ifa.instr, mem_word(fetch_addr));
        chk("m_instr_pc", ifa.instr_pc, fetch_addr);
      end
`ifdef FETCH_PERF_EN
      chk("m_fetch_count", ifa.fetch_count, exp_fc);
      chk("m_stall_cycles", ifa.stall_cycles, exp_st);
`endif
      p_req = ifa.mem_req;
      p_ack = ifa.mem_ack;
      p_vld = ifa.instr_valid;
      p_rdy = ifa.instr_ready;
      p_inc = ifa.inc_pc;
      if (ifa.inc_pc) fetch_addr = ifa.pc_addr;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int          reqs, valids, unstable;
    logic [31:0] a0, ipc, ins;
`ifdef FETCH_PERF_EN
    logic [31:0] st0;
`endif
    ifa.pc_addr = '0; ifa.mem_ack = 1'b0; ifa.mem_rdata = '0; ifa.instr_ready = 1'b0;
    ifb.pc_addr = '0; ifb.mem_ack = 1'b0; ifb.mem_rdata = '0; ifb.instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b1;

    // zero-wait first fetch
    step(); chk("t1_req_c1", ifa.mem_req, 1); chk("t1_addr_c1", ifa.mem_addr, 0);
    step(); chk("t1_vld_c2", ifa.instr_valid, 1); chk("t1_instr_c2", ifa.instr, 32'h00A00093);
            chk("t1_ipc_c2", ifa.instr_pc, 0);
    step(); chk("t1_inc_c3", ifa.inc_pc, 1); chk("t1_vld_c3", ifa.instr_valid, 0);
    step(); chk("t1_req_c4", ifa.mem_req, 1); chk("t1_addr_c4", ifa.mem_addr, 1);
    run_fetch(reqs, valids, a0, ipc, ins, unstable);
    chk("t1_ipc_addr1", ipc, 1);
    chk("t1_instr_addr1", ins, 32'h13569BDF);

    // five wait cycles
    wait_cfg = 5;
`ifdef FETCH_PERF_EN
    st0 = ifa.stall_cycles;
`endif
    run_fetch(reqs, valids, a0, ipc, ins, unstable);
    chk("t2_req_cycles", reqs, 6);
    chk("t2_valid_cycles", valids, 1);
    chk("t2_addr_stable", unstable, 0);
    chk("t2_addr", a0, 2);
    chk("t2_ipc", ipc, 2);
`ifdef FETCH_PERF_EN
    chk("t2_stall", ifa.stall_cycles - st0, 5);
`endif
    wait_cfg = 0;

    // decoder holds ready low for ten cycles
    stall_cfg = 10;
`ifdef FETCH_PERF_EN
    st0 = ifa.stall_cycles;
`endif
    run_fetch(reqs, valids, a0, ipc, ins, unstable);
    chk("t3_req_cycles", reqs, 1);
    chk("t3_valid_cycles", valids, 11);
    chk("t3_ipc", ipc, 3);
`ifdef FETCH_PERF_EN
    chk("t3_stall", ifa.stall_cycles - st0, 10);
`endif
    stall_cfg = 0;

    // jump to 0x40 on the next advance
    jmp_vld = 1'b1; jmp_tgt = 32'h40;
    run_fetch(reqs, valids, a0, ipc, ins, unstable);
    chk("t4_pre_addr", a0, 4);
    run_fetch(reqs, valids, a0, ipc, ins, unstable);
    chk("t4_jump_addr", a0, 32'h40);
    chk("t4_jump_ipc", ipc, 32'h40);
    chk("t4_jump_instr", ins, 32'h13179BDF);
    run_fetch(reqs, valids, a0, ipc, ins, unstable);
    chk("t4_after_jump", a0, 32'h41);

    // reset mid-request, stray ack during reset and IDLE
    wait_cfg = 3;
    step();
    chk("t5_in_req", ifa.mem_req, 1);
    #1 rst_a = 1'b0; ifa.pc_addr = '0;
    #1 chk("t5_async_drop", ifa.mem_req, 0);
    ifa.mem_ack = 1'b1; ifa.mem_rdata = 32'hDEADBEEF; ifa.instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b1;
    req_run = 0; val_run = 0; wait_cfg = 0;
    step(); chk("t5_req", ifa.mem_req, 1); chk("t5_addr", ifa.mem_addr, 0);
            chk("t5_no_stray_vld", ifa.instr_valid, 0);
    step(); chk("t5_vld", ifa.instr_valid, 1); chk("t5_instr", ifa.instr, 32'h00A00093);
    step(); chk("t5_inc", ifa.inc_pc, 1);

    // memory timeout on the MAX_WAIT=4 instance
    step();
    rst_b = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("t6_req_held", ifb.mem_req, 1);
      chk("t6_no_err_yet", ifb.fetch_err, 0);
    end
    step();
    chk("t6_err", ifb.fetch_err, 1);
    chk("t6_req_drop", ifb.mem_req, 0);
    ifb.mem_ack = 1'b1; ifb.mem_rdata = 32'h12345678; ifb.instr_ready = 1'b1;
    repeat (3) step();
    chk("t6_err_sticky", ifb.fetch_err, 1);
    chk("t6_late_ack_vld", ifb.instr_valid, 0);
    chk("t6_late_ack_instr", ifb.instr, 0);
    chk("t6_quiet_req", ifb.mem_req, 0);
    chk("t6_quiet_inc", ifb.inc_pc, 0);
    ifb.mem_ack = 1'b0;
    rst_b = 1'b0;
    #1 chk("t6_rst_clears", ifb.fetch_err, 0);

    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
